alu_result_buffer: RTL and testbench
====================================

// Module: alu_result_buffer
// PURPOSE
//  Downstream stage of the 4-bit adder/subtractor.
//  - Captures each corrected magnitude, its carry-out and the operation select.
//  - Derives sign, carry and zero flags from them.
//  - Holds results in a small synchronous FIFO behind valid/ready handshakes.
//  - Keeps saturating statistics counters for the ALU datapath.
// PARAMETERS
//  WIDTH  4  result magnitude width (matches adder/subtractor)
//  DEPTH  4  FIFO entries; power of two, >= 2
//  CNT_W  8  width of statistics counters
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  clear      in   1      synchronous flush of FIFO and counters
//  in_valid   in   1      upstream result valid
//  in_ready   out  1      buffer can accept (= !full)
//  in_mag     in   WIDTH  result magnitude from adder/subtractor
//  in_cout    in   1      adder carry-out
//  in_sub     in   1      operation select: 1 = A-B, 0 = A+B
//  out_valid  out  1      head entry valid (= !empty)
//  out_ready  in   1      downstream accepts head entry
//  out_mag    out  WIDTH  head magnitude
//  out_neg    out  1      head result negative (subtract, A<B)
//  out_carry  out  1      head unsigned add overflow
//  out_zero   out  1      head magnitude == 0
//  res_cnt    out  CNT_W  accepted results, saturating
//  ovf_cnt    out  CNT_W  accepted results with out_carry=1, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): pointers and occupancy 0; out_valid=0; out_mag/flags=0;
//    res_cnt=ovf_cnt=0. in_ready=1 once reset is released.
//  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
//  - Flags are computed at push and stored with the entry:
//    neg = in_sub & ~in_cout; carry = ~in_sub & in_cout; zero = (in_mag == 0).
//  - Subtract with A==B gives cout=1, so the result is mag=0, neg=0, zero=1.
//  - Latency: a pushed entry is visible at the outputs on the next edge. There is no
//    combinational bypass from in_* to out_*.
//  - Outputs come from the head entry. Outputs hold stable while out_valid & !out_ready.
//  - in_ready and out_valid derive only from registered occupancy. There is no
//    in->out combinational path in either direction.
//  - Occupancy states:
//    EMPTY -> PARTIAL on push.
//    PARTIAL -> FULL on push without pop at occupancy DEPTH-1.
//    PARTIAL -> EMPTY on pop without push at occupancy 1.
//    FULL -> PARTIAL on pop.
//  - Push and pop in the same cycle: occupancy unchanged, both pointers advance.
//  - When FULL, in_ready=0 even if out_ready=1, so no push occurs that cycle.
//  - Pointers are log2(DEPTH) bits and wrap naturally. Occupancy counter is log2(DEPTH)+1 bits.
//  - Counters: res_cnt increments on every push. ovf_cnt increments on a push with carry=1.
//    Both hold at all-ones.
//  - clear=1 at an edge: occupancy and pointers are set to 0 and counters to 0.
//    Any same-cycle push or pop is discarded. clear dominates handshakes.
//  - Reset asserted mid-transfer: all contents are lost immediately (async). No partial entry survives.
// STRUCTURE
//  - Shared include alu_defs.vh: ALU_WIDTH=4, flag bit indices (FLG_NEG=0, FLG_CARRY=1,
//    FLG_ZERO=2), FLG_W=3. Each entry stores {flags, mag}, WIDTH+FLG_W bits wide.
//  - Sub-module alu_result_fifo(clk, rst_n, clear, push, pop, wdata, rdata, full, empty),
//    parameterised by DATA_W and DEPTH.
//  - Top level holds the flag derivation, handshake glue and counters.
// TESTING
//  1. Reset, then push add mag=4'h7 cout=0 -> next cycle out_valid=1, out_mag=7,
//     neg=0, carry=0, zero=0; res_cnt=1.
//  2. Push add mag=4'h2 cout=1 (9+9) -> out_carry=1; ovf_cnt=1. Push sub mag=4'h3 cout=0
//     (2-5) -> out_neg=1, out_carry=0.
//  3. Push sub mag=0 cout=1 (6-6) -> out_zero=1, out_neg=0, out_carry=0.
//  4. out_ready=0, push 4 entries -> in_ready=0 after the 4th. A 5th in_valid is ignored.
//     Then hold out_ready=1 and in_valid=1 together -> steady push+pop, order preserved, 1 entry per cycle.
//  5. Fill with 2 entries, assert clear together with in_valid=1 and out_ready=1
//     -> next cycle out_valid=0, res_cnt=0, ovf_cnt=0, in_ready=1.
//  6. CNT_W=2: 5 pushes with carry -> res_cnt=ovf_cnt=3 (saturated).
//     Async rst_n pulse mid-stream -> out_valid=0 and counters=0 without a clock edge.

Source files
------------

// File: rtl/alu_result_buffer_pkg.sv
// alu_result_buffer_pkg: shared ALU widths, flag bit positions and flag derivation
package alu_result_buffer_pkg;
  localparam int ALU_WIDTH = 4;
  localparam int FLG_NEG   = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_W     = 3;
  // A subtract borrows (cout=0) only when A<B; an add overflows when cout=1.
  function automatic logic [FLG_W-1:0] alu_flags(input logic sub, input logic cout, input logic is_zero);
    logic [FLG_W-1:0] f;
    f            = '0;
    f[FLG_NEG]   = sub & ~cout;
    f[FLG_CARRY] = ~sub & cout;
    f[FLG_ZERO]  = is_zero;
    return f;
  endfunction
endpackage

// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: upstream result handshake and downstream head-entry handshake
interface alu_result_buffer_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mag;
  logic             in_cout;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mag;
  logic             out_neg;
  logic             out_carry;
  logic             out_zero;
  modport slave (input in_valid, in_mag, in_cout, in_sub, out_ready,
                 output in_ready, out_valid, out_mag, out_neg, out_carry, out_zero);
  modport master (output in_valid, in_mag, in_cout, in_sub, out_ready,
                  input in_ready, out_valid, out_mag, out_neg, out_carry, out_zero);
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: synchronous FIFO with registered occupancy and synchronous flush
module alu_result_fifo #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_cnt;
  logic              w_push;
  logic              w_pop;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  assign w_push = push & ~full & ~clear;
  assign w_pop  = pop & ~empty & ~clear;
  assign rdata  = r_mem[r_rptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push != w_pop) r_cnt <= w_push ? r_cnt + (AW+1)'(1) : r_cnt - (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: flags each adder/subtractor result, queues it, and counts results/overflows
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  alu_result_buffer_if.slave  bus,
  output logic [CNT_W-1:0]    res_cnt,
  output logic [CNT_W-1:0]    ovf_cnt
);
  localparam int DW = WIDTH + FLG_W;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_wdata;
  logic [DW-1:0]    w_rdata;
  logic [DW-1:0]    w_head;
  logic [FLG_W-1:0] w_flags;
  logic [CNT_W-1:0] r_res_cnt;
  logic [CNT_W-1:0] r_ovf_cnt;
  assign w_push  = bus.in_valid & ~w_full & ~clear;
  assign w_pop   = bus.out_ready & ~w_empty & ~clear;
  assign w_flags = alu_flags(bus.in_sub, bus.in_cout, bus.in_mag == '0);
  assign w_wdata = {w_flags, bus.in_mag};
  alu_result_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );
  // Stale storage is masked so an empty buffer always presents zero outputs.
  assign w_head        = w_empty ? '0 : w_rdata;
  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_mag   = w_head[WIDTH-1:0];
  assign bus.out_neg   = w_head[WIDTH+FLG_NEG];
  assign bus.out_carry = w_head[WIDTH+FLG_CARRY];
  assign bus.out_zero  = w_head[WIDTH+FLG_ZERO];
  assign res_cnt       = r_res_cnt;
  assign ovf_cnt       = r_ovf_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_cnt <= '0;
      r_ovf_cnt <= '0;
    end else if (clear) begin
      r_res_cnt <= '0;
      r_ovf_cnt <= '0;
    end else if (w_push) begin
      if (~&r_res_cnt) r_res_cnt <= r_res_cnt + CNT_W'(1);
      if (w_flags[FLG_CARRY] && ~&r_ovf_cnt) r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed and random stimulus against an operand-level reference model
module tb_alu_result_buffer;
  localparam int DEPTH = 4;
  typedef struct {
    int mag;
    bit neg;
    bit carry;
    bit zero;
  } ent_t;
  logic clk;
  logic rst_n;
  logic clear;
  logic [7:0] res_cnt;
  logic [7:0] ovf_cnt;
  logic [1:0] res_cnt2;
  logic [1:0] ovf_cnt2;
  int errs;
  int checks;
  int tot;
  int ovfn;
  ent_t q[$];
  ent_t pend;
  alu_result_buffer_if #(.WIDTH(4)) if0 ();
  alu_result_buffer_if #(.WIDTH(4)) if2 ();
  assign if2.in_valid  = if0.in_valid;
  assign if2.in_mag    = if0.in_mag;
  assign if2.in_cout   = if0.in_cout;
  assign if2.in_sub    = if0.in_sub;
  assign if2.out_ready = if0.out_ready;
  alu_result_buffer #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0), .res_cnt(res_cnt), .ovf_cnt(ovf_cnt));
  alu_result_buffer #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if2), .res_cnt(res_cnt2), .ovf_cnt(ovf_cnt2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int sat(input int v, input int m);
    return v > m ? m : v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    ent_t h;
    h = '{0, 1'b0, 1'b0, 1'b0};
    if (q.size() > 0) h = q[0];
    chk("in_ready", 32'(if0.in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(if0.out_valid), 32'(q.size() > 0));
    chk("out_mag", 32'(if0.out_mag), 32'(h.mag));
    chk("out_neg", 32'(if0.out_neg), 32'(h.neg));
    chk("out_carry", 32'(if0.out_carry), 32'(h.carry));
    chk("out_zero", 32'(if0.out_zero), 32'(h.zero));
    chk("res_cnt", 32'(res_cnt), 32'(sat(tot, 255)));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(sat(ovfn, 255)));
    chk("res_cnt_w2", 32'(res_cnt2), 32'(sat(tot, 3)));
    chk("ovf_cnt_w2", 32'(ovf_cnt2), 32'(sat(ovfn, 3)));
  endtask
  task automatic cycle();
    bit push;
    bit pop;
    @(posedge clk);
    push = if0.in_valid && q.size() < DEPTH;
    pop  = if0.out_ready && q.size() > 0;
    if (clear) begin
      q.delete();
      tot  = 0;
      ovfn = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(pend);
        tot++;
        if (pend.carry) ovfn++;
      end
    end
    #1 check_all();
  endtask
  task automatic drive(input bit v, input int a, input int b, input bit sub, input bit rdy, input bit clr);
    pend.mag   = sub ? (a >= b ? a - b : b - a) : (a + b) % 16;
    pend.neg   = sub && a < b;
    pend.carry = !sub && a + b > 15;
    pend.zero  = pend.mag == 0;
    if0.in_valid  = v;
    if0.in_mag    = 4'(pend.mag);
    if0.in_cout   = sub ? (a >= b) : (a + b > 15);
    if0.in_sub    = sub;
    if0.out_ready = rdy;
    clear         = clr;
    cycle();
  endtask
  task automatic rnd(input bit v, input bit rdy, input bit clr);
    drive(v, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rdy, clr);
  endtask
  initial begin
    errs   = 0;
    checks = 0;
    tot    = 0;
    ovfn   = 0;
    rst_n  = 1'b0;
    clear  = 1'b0;
    if0.in_valid  = 1'b0;
    if0.in_mag    = '0;
    if0.in_cout   = 1'b0;
    if0.in_sub    = 1'b0;
    if0.out_ready = 1'b0;
    pend = '{0, 1'b0, 1'b0, 1'b0};
    #2 check_all();
    @(posedge clk);
    #1 check_all();
    rst_n = 1'b1;
    drive(1, 7, 0, 0, 0, 0);
    drive(1, 9, 9, 0, 1, 0);
    drive(1, 2, 5, 1, 1, 0);
    drive(1, 6, 6, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) rnd(1, 0, 0);
    for (int i = 0; i < 12; i++) rnd(1, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0);
    drive(1, 3, 4, 0, 0, 0);
    drive(1, 15, 1, 0, 0, 0);
    drive(1, 8, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 9, 9, 0, 1, 0);
    #2 rst_n = 1'b0;
    q.delete();
    tot  = 0;
    ovfn = 0;
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++)
      rnd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 300; i++) rnd(1, 1'($urandom_range(0, 3) != 0), 0);
    for (int i = 0; i < 20; i++) drive(1, 12, 9, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
